// File: rtl/vedic6_mac_if.sv
// Operand/result bundle for the 6x6 multiply-accumulate block.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on operands, sum_valid/sum_ready on results.
interface vedic6_mac_if #(
    parameter int ACC_W = 16
);
    logic [5:0]       a;
    logic [5:0]       b;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             sum_ready;

    // Producer/consumer side: drives operands, takes results.
    modport master (
        output a, b, in_valid, sum_ready,
        input  in_ready, sum, sum_valid
    );

    // MAC side: takes operands, drives results.
    modport slave (
        input  a, b, in_valid, sum_ready,
        output in_ready, sum, sum_valid
    );
endinterface

// File: rtl/vedic6_mac.sv
// Vedic 3x3 multiplier: vertical-and-crosswise column sums.
// Latency: combinational.
// Backpressure: none.
module vedic3x3 (
    input  logic [2:0] x_i,
    input  logic [2:0] y_i,
    output logic [5:0] p_o
);
    logic [1:0] col1;
    logic [1:0] col2;
    logic [1:0] col3;

    assign col1 = 2'(x_i[1] & y_i[0]) + 2'(x_i[0] & y_i[1]);
    assign col2 = 2'(x_i[2] & y_i[0]) + 2'(x_i[1] & y_i[1]) + 2'(x_i[0] & y_i[2]);
    assign col3 = 2'(x_i[2] & y_i[1]) + 2'(x_i[1] & y_i[2]);
    // Column weights 2^0..2^4; carries ripple through the final add.
    assign p_o  = 6'(x_i[0] & y_i[0]) + (6'(col1) << 1) + (6'(col2) << 2)
                + (6'(col3) << 3) + (6'(x_i[2] & y_i[2]) << 4);
endmodule

// Vedic 6x6 multiplier built from four 3x3 crosswise blocks.
// Latency: combinational.
// Backpressure: none.
module vedic6x6 (
    input  logic [5:0]  x_i,
    input  logic [5:0]  y_i,
    output logic [11:0] p_o
);
    logic [5:0] p_ll;
    logic [5:0] p_lh;
    logic [5:0] p_hl;
    logic [5:0] p_hh;

    vedic3x3 u_ll (.x_i(x_i[2:0]), .y_i(y_i[2:0]), .p_o(p_ll));
    vedic3x3 u_lh (.x_i(x_i[2:0]), .y_i(y_i[5:3]), .p_o(p_lh));
    vedic3x3 u_hl (.x_i(x_i[5:3]), .y_i(y_i[2:0]), .p_o(p_hl));
    vedic3x3 u_hh (.x_i(x_i[5:3]), .y_i(y_i[5:3]), .p_o(p_hh));

    // Low, crosswise (weight 8) and high (weight 64) partials.
    assign p_o = 12'(p_ll) + ((12'(p_lh) + 12'(p_hl)) << 3) + (12'(p_hh) << 6);
endmodule

// Sums COUNT unsigned 6x6 products, then presents the total until taken.
// Latency: sum_valid rises one edge after the last operand accept.
// Backpressure: in_ready drops from last accept until the sum is handed off.
module vedic6_mac #(
    parameter int COUNT = 4,
    parameter int ACC_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    vedic6_mac_if.slave  bus
);
    if (COUNT < 1 || COUNT > 16) begin : g_bad_count
        $error("vedic6_mac: COUNT must be 1..16");
    end
    if (ACC_W < 12 + $clog2(COUNT)) begin : g_bad_acc_w
        $error("vedic6_mac: ACC_W too narrow for COUNT products");
    end

    typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_HOLD} state_t;

    state_t           state_q, state_d;
    logic [5:0]       a_q, a_d;
    logic [5:0]       b_q, b_d;
    logic             pend_q, pend_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             sum_valid_q, sum_valid_d;
    logic [11:0]      prod;
    logic             accept;

    vedic6x6 u_mul (.x_i(a_q), .y_i(b_q), .p_o(prod));

    assign accept        = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.sum       = acc_q;

    // Next state: capture stage feeds the add stage one edge later; clr overrides all.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        pend_d      = 1'b0;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        sum_valid_d = sum_valid_q;

        if (pend_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    a_d    = bus.a;
                    b_d    = bus.b;
                    pend_d = 1'b1;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q + 5'd1 == 5'(COUNT)) begin
                        state_d    = ST_FLUSH;
                        in_ready_d = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                // Last product lands in the accumulator on this edge.
                state_d     = ST_HOLD;
                sum_valid_d = 1'b1;
            end
            ST_HOLD: begin
                if (bus.sum_ready) begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_ACC;
                    in_ready_d  = 1'b1;
                    sum_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_ACC;
                in_ready_d  = 1'b1;
                sum_valid_d = 1'b0;
            end
        endcase

        if (clr) begin
            state_d     = ST_ACC;
            a_d         = a_q;
            b_d         = b_q;
            pend_d      = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            sum_valid_d = 1'b0;
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            a_q         <= '0;
            b_q         <= '0;
            pend_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pend_q      <= pend_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
        end
    end
endmodule
